// File: rtl/regs_ctrl_pkg.sv
// Shared constants for the register-transfer controller: opcodes, FSM states
// and bus source codes.
package regs_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam logic [1:0] BUS_REG = 2'b00;
  localparam logic [1:0] BUS_IMM = 2'b01;
  localparam logic [1:0] BUS_G   = 2'b10;

endpackage

// File: rtl/regs_ctrl_idx_to_onehot.sv
// Register index to one-hot select; indices outside 0..SIZE-1 select nothing.
module idx_to_onehot #(
  parameter int SIZE = 8,
  parameter int IDX  = $clog2(SIZE)
) (
  input  logic [IDX-1:0]  idx,
  input  logic            en,
  output logic [SIZE-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (en && (32'(idx) == i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/regs_ctrl.sv
// Multi-cycle control unit sequencing MV/MVI/ADD/SUB over a register file,
// an A/G ALU pair and a shared bus.
module regs_ctrl
  import regs_ctrl_pkg::*;
#(
  parameter int  SIZE = 8,
  localparam int IDX  = $clog2(SIZE),
  localparam int IW   = 2 + 2 * IDX
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IW-1:0]   instr,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] sel_r,
  output logic [SIZE-1:0] sel_r2,
  output logic [SIZE-1:0] sel_w,
  output logic            wr_en,
  output logic [1:0]      bus_sel,
  output logic            load_a,
  output logic            load_g,
  output logic            alu_sub,
  output logic [7:0]      retired,
  output state_t          state
);

  // Handshake: start/instr are accepted on a rising edge only while busy=0;
  // busy stays high until the cycle after done, so start is ignored meanwhile.

  state_t         state_next;
  logic [IW-1:0]  ir;
  logic [1:0]     op;
  logic [IDX-1:0] rx;
  logic [IDX-1:0] ry;
  logic [IDX-1:0] r_idx;
  logic           r_en;
  logic           r2_en;

  assign op   = ir[IW-1:IW-2];
  assign rx   = ir[2*IDX-1:IDX];
  assign ry   = ir[IDX-1:0];
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) ir <= instr;
      if (done) retired <= retired + 8'd1;
    end
  end

  // Outputs depend only on state and IR, so reset clears them immediately.
  always_comb begin
    state_next = state;
    r_idx      = ry;
    r_en       = 1'b0;
    r2_en      = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    bus_sel    = BUS_REG;
    load_a     = 1'b0;
    load_g     = 1'b0;
    alu_sub    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = T1;
      end
      T1: begin
        case (op)
          OP_MV: begin
            r_idx      = ry;
            r_en       = 1'b1;
            bus_sel    = BUS_REG;
            wr_en      = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
          end
          OP_MVI: begin
            bus_sel    = BUS_IMM;
            wr_en      = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
          end
          default: begin
            r_idx      = rx;
            r_en       = 1'b1;
            bus_sel    = BUS_REG;
            load_a     = 1'b1;
            state_next = T2;
          end
        endcase
      end
      T2: begin
        r2_en      = 1'b1;
        load_g     = 1'b1;
        alu_sub    = (op == OP_SUB);
        state_next = T3;
      end
      T3: begin
        bus_sel    = BUS_G;
        wr_en      = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  idx_to_onehot #(.SIZE(SIZE)) u_dec_r (
    .idx    (r_idx),
    .en     (r_en),
    .onehot (sel_r)
  );

  idx_to_onehot #(.SIZE(SIZE)) u_dec_r2 (
    .idx    (ry),
    .en     (r2_en),
    .onehot (sel_r2)
  );

  // Write select follows wr_en so sel_w is zero whenever nothing is written.
  idx_to_onehot #(.SIZE(SIZE)) u_dec_w (
    .idx    (rx),
    .en     (wr_en),
    .onehot (sel_w)
  );

endmodule
